// File: rtl/switch_pkg.sv
// Shared constants and types for the slide-switch conditioning block.
package switch_pkg;

    localparam int unsigned SW_N             = 10;
    localparam int unsigned DEBOUNCE_DEFAULT = 500000;

    typedef logic [SW_N-1:0] sw_vec_t;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchroniser, persistence counter, stable level and change pulse.
module debounce_bit
    import switch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw_i,
    output logic sw_stable_o,
    output logic sw_changed_o
);

    localparam int unsigned     CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             changed_q, changed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any sample matching the stable level restarts the count, so glitches never accumulate.
    always_comb begin
        cnt_d     = '0;
        stable_d  = stable_q;
        changed_d = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CntMax) begin
                stable_d  = sync2_q;
                changed_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            stable_q  <= 1'b0;
            changed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sw_raw_i;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign sw_stable_o  = stable_q;
    assign sw_changed_o = changed_q;

endmodule

// File: rtl/switch_debouncer.sv
// Per-bit debouncer bank for the board slide switches feeding the data-memory switch port.
// Define SWITCH_IRQ_EN to build the sticky irq_pending flag; otherwise it is tied low.
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int unsigned N               = SW_N,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] sw_raw,
    output logic [N-1:0] sw_stable,
    output logic [N-1:0] sw_changed,
    output logic         any_change,
    input  logic         irq_clr,
    output logic         irq_pending
);

    for (genvar i = 0; i < N; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk         (clk),
            .reset       (reset),
            .sw_raw_i    (sw_raw[i]),
            .sw_stable_o (sw_stable[i]),
            .sw_changed_o(sw_changed[i])
        );
    end

    assign any_change = |sw_changed;

`ifdef SWITCH_IRQ_EN
    logic irq_q;

    // A new change outranks a simultaneous clear so no event is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else if (any_change) begin
            irq_q <= 1'b1;
        end else if (irq_clr) begin
            irq_q <= 1'b0;
        end
    end

    assign irq_pending = irq_q;
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr;
    assign irq_pending    = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer (N=10, DEBOUNCE_CYCLES=4), both irq build options.
module tb_switch_debouncer;

    localparam int N = 10;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] sw_raw;
    logic [N-1:0] sw_stable;
    logic [N-1:0] sw_changed;
    logic         any_change;
    logic         irq_clr;
    logic         irq_pending;

    switch_debouncer #(
        .N              (N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_raw     (sw_raw),
        .sw_stable  (sw_stable),
        .sw_changed (sw_changed),
        .any_change (any_change),
        .irq_clr    (irq_clr),
        .irq_pending(irq_pending)
    );

    always #5 clk = ~clk;

    // Reference model: raw pipeline of two samples, then a window of the last D samples;
    // a bit flips when its whole window disagrees with its stable level.
    logic [N-1:0] p1, p2, m_stable, m_changed;
    logic         m_irq;
    logic [D-1:0] hist [N];
    int           checks = 0;
    int           passes = 0;

    task automatic tick();
        logic [N-1:0] nc;
        logic         any_prev;
        @(posedge clk);
        if (reset) begin
            p1 = '0; p2 = '0; m_stable = '0; m_changed = '0; m_irq = 1'b0;
            for (int b = 0; b < N; b++) hist[b] = '0;
        end else begin
            any_prev = |m_changed;
            nc = '0;
            for (int b = 0; b < N; b++) begin
                hist[b] = {hist[b][D-2:0], p2[b]};
                if (hist[b] == {D{~m_stable[b]}}) begin
                    m_stable[b] = ~m_stable[b];
                    nc[b] = 1'b1;
                end
            end
`ifdef SWITCH_IRQ_EN
            if (any_prev) m_irq = 1'b1;
            else if (irq_clr) m_irq = 1'b0;
`else
            m_irq = 1'b0 & any_prev;
`endif
            m_changed = nc;
            p2 = p1;
            p1 = sw_raw;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; irq_clr = 1'b0; sw_raw = 10'h3FF;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (sw_stable !== 10'h000) $display("FAIL reset_stable: got %h want 000", sw_stable);
            else passes++;
            checks++;
            if (sw_changed !== 10'h000) $display("FAIL reset_changed: got %h want 000", sw_changed);
            else passes++;
            checks++;
            if (irq_pending !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq_pending);
            else passes++;
        end
    endtask

    task automatic test_single_rise();
        reset = 1'b0; sw_raw = 10'h001;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if (sw_stable !== m_stable || sw_changed !== m_changed)
                $display("FAIL rise_model e%0d: got %h/%h want %h/%h", e, sw_stable, sw_changed,
                         m_stable, m_changed);
            else passes++;
            if (e == 5) begin
                checks++;
                if (sw_stable !== 10'h000) $display("FAIL rise_early: got %h want 000", sw_stable);
                else passes++;
            end
            if (e == 6) begin
                checks++;
                if (sw_stable !== 10'h001 || sw_changed !== 10'h001 || any_change !== 1'b1)
                    $display("FAIL rise_edge6: got %h/%h/%b want 001/001/1", sw_stable,
                             sw_changed, any_change);
                else passes++;
            end
            if (e == 7) begin
                checks++;
                if (sw_changed !== 10'h000 || any_change !== 1'b0)
                    $display("FAIL rise_pulse_len: got %h/%b want 000/0", sw_changed, any_change);
                else passes++;
            end
        end
    endtask

    task automatic test_glitch();
        logic [N-1:0] pat [13];
        for (int i = 0; i < 13; i++) pat[i] = 10'h001;
        for (int i = 0; i < 3; i++) begin
            pat[i] = 10'h005;
            pat[i+4] = 10'h005;
        end
        for (int i = 0; i < 13; i++) begin
            sw_raw = pat[i];
            tick();
            checks++;
            if (sw_stable[2] !== 1'b0 || sw_changed !== 10'h000)
                $display("FAIL glitch c%0d: got stable2=%b changed=%h want 0/000", i,
                         sw_stable[2], sw_changed);
            else passes++;
            checks++;
            if (sw_stable !== m_stable) $display("FAIL glitch_model: got %h want %h", sw_stable,
                                                 m_stable);
            else passes++;
        end
    endtask

    task automatic test_multi();
        int pulses = 0;
        sw_raw = 10'h000;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (sw_stable !== 10'h000) $display("FAIL multi_base: got %h want 000", sw_stable);
        else passes++;
        sw_raw = 10'h2A5;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (sw_changed !== 10'h000) begin
                pulses++;
                checks++;
                if (sw_changed !== 10'h2A5) $display("FAIL multi_pulse: got %h want 2A5",
                                                     sw_changed);
                else passes++;
            end
            checks++;
            if (sw_changed !== m_changed) $display("FAIL multi_model: got %h want %h", sw_changed,
                                                   m_changed);
            else passes++;
        end
        checks++;
        if (pulses !== 1) $display("FAIL multi_count: got %0d want 1", pulses);
        else passes++;
        checks++;
        if (sw_stable !== 10'h2A5) $display("FAIL multi_stable: got %h want 2A5", sw_stable);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int first = 0;
        sw_raw = 10'h2B5;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (sw_stable !== 10'h000 || sw_changed !== 10'h000)
            $display("FAIL midreset: got %h/%h want 000/000", sw_stable, sw_changed);
        else passes++;
        reset = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            checks++;
            if (sw_stable !== m_stable) $display("FAIL midreset_model e%0d: got %h want %h", e,
                                                 sw_stable, m_stable);
            else passes++;
            if (sw_stable === 10'h2B5) begin
                first = e;
                break;
            end
        end
        checks++;
        if (first !== D + 2) $display("FAIL midreset_latency: got %0d want %0d", first, D + 2);
        else passes++;
    endtask

    task automatic test_irq();
        int k = 0;
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        sw_raw = 10'h000;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (m_changed != '0) begin
                k = i;
                break;
            end
        end
        checks++;
        if (k == 0 || any_change !== 1'b1) $display("FAIL irq_change: got %b want 1", any_change);
        else passes++;
`ifdef SWITCH_IRQ_EN
        checks++;
        if (irq_pending !== 1'b0) $display("FAIL irq_before: got %b want 0", irq_pending);
        else passes++;
        irq_clr = 1'b1;
        tick();
        checks++;
        if (irq_pending !== 1'b1) $display("FAIL irq_set_wins: got %b want 1", irq_pending);
        else passes++;
        tick();
        checks++;
        if (irq_pending !== 1'b0) $display("FAIL irq_clear: got %b want 0", irq_pending);
        else passes++;
        irq_clr = 1'b0;
`else
        for (int i = 0; i < 4; i++) begin
            irq_clr = i[0];
            tick();
            checks++;
            if (irq_pending !== 1'b0) $display("FAIL irq_tied: got %b want 0", irq_pending);
            else passes++;
        end
        irq_clr = 1'b0;
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 4) == 0) sw_raw[b] = ~sw_raw[b];
            irq_clr = ($urandom_range(0, 3) == 0);
            tick();
            checks++;
            if (sw_stable !== m_stable || sw_changed !== m_changed ||
                any_change !== (|m_changed) || irq_pending !== m_irq)
                $display("FAIL random c%0d: got %h/%h/%b/%b want %h/%h/%b/%b", c, sw_stable,
                         sw_changed, any_change, irq_pending, m_stable, m_changed, |m_changed,
                         m_irq);
            else passes++;
        end
        irq_clr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq_clr = 1'b0; sw_raw = '0;
        test_reset();
        test_single_rise();
        test_glitch();
        test_multi();
        test_reset_mid();
        test_irq();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
